// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, read-owner
// encoding and default timing parameters.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DMA_WAIT  = 2'd1,
    DMA_FORCE = 2'd2
  } arb_state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int LAT_DEFAULT        = 1;
  localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/dmem_rtag_pipe.sv
// LAT-deep {valid, owner} shift register that follows each memory read until
// its data comes back; synchronous clear drops everything in flight.
module dmem_rtag_pipe
  import dmem_arbiter_pkg::*;
#(
  parameter int LAT = LAT_DEFAULT
) (
  input  logic clk,
  input  logic clr_i,
  input  logic vld_i,
  input  logic own_i,
  output logic vld_o,
  output logic own_o
);

  logic [LAT-1:0] vld_q, vld_d;
  logic [LAT-1:0] own_q, own_d;

  always_comb begin
    vld_d    = vld_q << 1;
    own_d    = own_q << 1;
    vld_d[0] = vld_i;
    own_d[0] = own_i;
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q <= vld_d;
      own_q <= own_d;
    end
  end

  assign vld_o = vld_q[LAT-1];
  assign own_o = own_q[LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU has fixed priority, a starvation
// counter forces one DMA win, and read data is steered back to its owner.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int LAT        = LAT_DEFAULT,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_m
);

  localparam int            CW       = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_MAX - 1);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          force_dma;
  logic          dma_lose;
  logic          tag_vld, tag_own;
  logic [DW-1:0] cpu_rdata_q, dma_rdata_q;

  // Issue stage: grant, stall and memory mux (all outputs held quiet in reset)
  always_comb begin
    force_dma = (state_q == DMA_FORCE) & dma_req;
    cpu_gnt   = ~rst & cpu_req & ~force_dma;
    dma_gnt   = ~rst & dma_req & ~cpu_gnt;
    stall_m   = ~rst & cpu_req & ~cpu_gnt;
    dma_lose  = dma_req & ~dma_gnt;
    mem_we    = (cpu_gnt & cpu_we) | (dma_gnt & dma_we);
    mem_re    = (cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we);
    mem_addr  = dma_gnt ? dma_addr  : cpu_addr;
    mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DMA_WAIT: begin
        // The loss that reaches STARVE_MAX goes straight to FORCE, which also
        // lets STARVE_MAX = 1 alternate with a continuous CPU stream.
        if (dma_lose) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == CNT_LAST) ? DMA_FORCE : DMA_WAIT;
        end
      end
      DMA_FORCE: state_d = DMA_FORCE;
      default:   state_d = IDLE;
    endcase
    if (~dma_req | dma_gnt) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Return stage: tag follows the read for LAT cycles
  dmem_rtag_pipe #(.LAT(LAT)) u_rtag (
    .clk   (clk),
    .clr_i (rst),
    .vld_i (mem_re),
    .own_i (dma_gnt ? OWN_DMA : OWN_CPU),
    .vld_o (tag_vld),
    .own_o (tag_own)
  );

  assign cpu_rvalid = ~rst & tag_vld & (tag_own == OWN_CPU);
  assign dma_rvalid = ~rst & tag_vld & (tag_own == OWN_DMA);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign dma_rdata  = dma_rvalid ? mem_rdata : dma_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
      if (dma_rvalid) dma_rdata_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (LAT = 1 and LAT = 2) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_dmem_arbiter;

  localparam int SM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;

  logic [1:0]  cgnt, dgnt, crv, drv, mwe, mre, stl;
  logic [31:0] crd [2];
  logic [31:0] drd [2];
  logic [31:0] maddr [2];
  logic [31:0] mwd [2];
  logic [31:0] mrd [2];
  logic [31:0] md1, md2a, md2b;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  dmem_arbiter #(.AW(32), .DW(32), .LAT(1), .STARVE_MAX(SM)) u_l1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cgnt[0]), .cpu_rvalid(crv[0]), .cpu_rdata(crd[0]),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dgnt[0]), .dma_rvalid(drv[0]), .dma_rdata(drd[0]),
    .mem_we(mwe[0]), .mem_re(mre[0]), .mem_addr(maddr[0]), .mem_wdata(mwd[0]),
    .mem_rdata(mrd[0]), .stall_m(stl[0])
  );

  dmem_arbiter #(.AW(32), .DW(32), .LAT(2), .STARVE_MAX(SM)) u_l2 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cgnt[1]), .cpu_rvalid(crv[1]), .cpu_rdata(crd[1]),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dgnt[1]), .dma_rvalid(drv[1]), .dma_rdata(drd[1]),
    .mem_we(mwe[1]), .mem_re(mre[1]), .mem_addr(maddr[1]), .mem_wdata(mwd[1]),
    .mem_rdata(mrd[1]), .stall_m(stl[1])
  );

  function automatic logic [31:0] rd_val(logic [31:0] a);
    case (a)
      32'h10:  return 32'hDEAD_BEEF;
      32'h04:  return 32'h1111_2222;
      32'h08:  return 32'h3333_4444;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Memory: read data appears LAT cycles after mem_re, junk otherwise
  always @(posedge clk) begin
    md1  <= mre[0] ? rd_val(maddr[0]) : (32'hBAD0_0000 ^ 32'(cyc));
    md2a <= mre[1] ? rd_val(maddr[1]) : (32'hBAD1_0000 ^ 32'(cyc));
    md2b <= md2a;
  end
  assign mrd[0] = md1;
  assign mrd[1] = md2b;

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s u%0d cyc %0d: got %0h want %0h", nm, k, cyc, act, exp);
    end
  endtask

  // Behavioural model
  typedef struct packed {
    logic        cg, dg, st, we, re;
    logic [31:0] addr, wd;
  } arb_t;

  typedef struct {
    int          k;
    int          due;
    bit          own;
    logic [31:0] d;
  } ret_t;

  ret_t        rq[$];
  int          m_cnt [2];
  logic [31:0] held_c [2];
  logic [31:0] held_d [2];

  function automatic arb_t arb(int k);
    arb_t r;
    bit   forced;
    forced = dma_req && (m_cnt[k] >= SM);
    r.cg   = !rst && cpu_req && !forced;
    r.dg   = !rst && dma_req && !r.cg;
    r.st   = !rst && cpu_req && !r.cg;
    r.we   = (r.cg && cpu_we) || (r.dg && dma_we);
    r.re   = (r.cg && !cpu_we) || (r.dg && !dma_we);
    r.addr = r.dg ? dma_addr : cpu_addr;
    r.wd   = r.dg ? dma_wdata : cpu_wdata;
    return r;
  endfunction

  function automatic int find(int k);
    foreach (rq[i]) if (rq[i].k == k) return i;
    return -1;
  endfunction

  initial begin
    arb_t        a;
    int          idx;
    logic        ecv, edv;
    logic [31:0] ecd, edd;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; held_c[k] = '0; held_d[k] = '0;
    end
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        for (int k = 0; k < 2; k++) begin
          a   = arb(k);
          ecv = 1'b0; edv = 1'b0; ecd = held_c[k]; edd = held_d[k];
          idx = find(k);
          if (!rst && idx >= 0 && rq[idx].due == cyc) begin
            if (rq[idx].own) begin edv = 1'b1; edd = rq[idx].d; end
            else             begin ecv = 1'b1; ecd = rq[idx].d; end
          end
          chk("cpu_gnt", k, cgnt[k], a.cg);
          chk("dma_gnt", k, dgnt[k], a.dg);
          chk("stall_m", k, stl[k], a.st);
          chk("mem_we", k, mwe[k], a.we);
          chk("mem_re", k, mre[k], a.re);
          chk("cpu_rvalid", k, crv[k], ecv);
          chk("dma_rvalid", k, drv[k], edv);
          chk("cpu_rdata", k, crd[k], ecd);
          chk("dma_rdata", k, drd[k], edd);
          if (a.cg || a.dg) chk("mem_addr", k, maddr[k], a.addr);
          if (a.we) chk("mem_wdata", k, mwd[k], a.wd);
        end
      end
      @(posedge clk);
      if (rst) begin
        rq.delete();
        for (int k = 0; k < 2; k++) begin
          m_cnt[k] = 0; held_c[k] = '0; held_d[k] = '0;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          a   = arb(k);
          idx = find(k);
          if (idx >= 0 && rq[idx].due == cyc) begin
            if (rq[idx].own) held_d[k] = rq[idx].d;
            else             held_c[k] = rq[idx].d;
            rq.delete(idx);
          end
          if (a.re) rq.push_back('{k, cyc + ((k == 0) ? 1 : 2), a.dg, rd_val(a.addr)});
          m_cnt[k] = (!dma_req || a.dg) ? 0 : m_cnt[k] + 1;
        end
      end
      cyc++;
    end
  end

  // Directed stimulus with hand-computed expectations
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    cpu_req = 1'b0;
    dma_req = 1'b0;
    repeat (n) next();
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    repeat (2) next();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_cpu_gnt", k, cgnt[k], 0);
      chk("rst_stall", k, stl[k], 0);
      chk("rst_mem_re", k, mre[k], 0);
      chk("rst_cpu_rdata", k, crd[k], 0);
      chk("rst_dma_rdata", k, drd[k], 0);
    end
    next();
    rst = 1'b0;
    idle(2);

    // CPU-only read of 0x10
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    @(negedge clk);
    chk("t1_cpu_gnt", 0, cgnt[0], 1);
    chk("t1_mem_re", 0, mre[0], 1);
    chk("t1_stall", 0, stl[0], 0);
    next();
    cpu_req = 0;
    @(negedge clk);
    chk("t1_rvalid_l1", 0, crv[0], 1);
    chk("t1_rdata_l1", 0, crd[0], 32'hDEAD_BEEF);
    chk("t1_stall_after", 0, stl[0], 0);
    next();
    @(negedge clk);
    chk("t1_rvalid_l2", 1, crv[1], 1);
    chk("t1_rdata_l2", 1, crd[1], 32'hDEAD_BEEF);
    idle(2);

    // DMA-only write of 0xAA to 0x20
    dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'hAA;
    @(negedge clk);
    chk("t2_dma_gnt", 0, dgnt[0], 1);
    chk("t2_mem_we", 0, mwe[0], 1);
    chk("t2_mem_addr", 0, maddr[0], 32'h20);
    chk("t2_mem_wdata", 0, mwd[0], 32'hAA);
    next();
    dma_req = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_no_crv", 1, crv[1], 0);
      chk("t2_no_drv", 1, drv[1], 0);
      next();
    end

    // Continuous CPU reads against a DMA read: forced DMA win in cycle 4
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    dma_req = 1; dma_we = 0; dma_addr = 32'h08;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) dma_req = 0;
      @(negedge clk);
      chk("t3_cpu_gnt", 0, cgnt[0], (i != 4));
      chk("t3_dma_gnt", 0, dgnt[0], (i == 4));
      chk("t3_stall", 0, stl[0], (i == 4));
      if (i == 5) begin
        chk("t3_dma_rvalid", 0, drv[0], 1);
        chk("t3_dma_rdata", 0, drd[0], 32'h3333_4444);
      end
      next();
    end
    cpu_req = 0;
    @(negedge clk);
    chk("t3_dma_rvalid_l2", 1, drv[1], 1);
    chk("t3_dma_rdata_l2", 1, drd[1], 32'h3333_4444);
    idle(3);

    // CPU read 0x4 then DMA read 0x8 back to back, LAT = 2
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h04;
    next();
    cpu_req = 0;
    dma_req = 1; dma_we = 0; dma_addr = 32'h08;
    next();
    dma_req = 0;
    @(negedge clk);
    chk("t4_cpu_rvalid", 1, crv[1], 1);
    chk("t4_cpu_rdata", 1, crd[1], 32'h1111_2222);
    chk("t4_dma_idle", 1, drv[1], 0);
    next();
    @(negedge clk);
    chk("t4_dma_rvalid", 1, drv[1], 1);
    chk("t4_dma_rdata", 1, drd[1], 32'h3333_4444);
    chk("t4_cpu_hold", 1, crd[1], 32'h1111_2222);
    next();

    // Mixed-owner stream checked by the model
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    next();
    cpu_req = 0; dma_req = 1; dma_we = 0; dma_addr = 32'h04;
    next();
    dma_req = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 32'h50; cpu_wdata = 32'h77;
    next();
    cpu_req = 0; dma_req = 1; dma_we = 0; dma_addr = 32'h10;
    next();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h08;
    dma_we = 1; dma_addr = 32'h60; dma_wdata = 32'h99;
    next();
    cpu_req = 0;
    next();
    idle(4);

    // DMA read, then reset before its data returns
    dma_req = 1; dma_we = 0; dma_addr = 32'h08;
    next();
    dma_req = 0;
    rst = 1;
    @(negedge clk);
    chk("t5_l1_no_rvalid", 0, drv[0], 0);
    next();
    rst = 0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("t5_dma_rvalid", k, drv[k], 0);
      chk("t5_cpu_rvalid", k, crv[k], 0);
      chk("t5_dma_gnt", k, dgnt[k], 0);
      chk("t5_mem_re", k, mre[k], 0);
      chk("t5_stall", k, stl[k], 0);
      chk("t5_dma_rdata", k, drd[k], 0);
      chk("t5_cpu_rdata", k, crd[k], 0);
    end
    idle(2);

    // Abandoned DMA request clears the loss streak
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h44;
    dma_we = 1; dma_addr = 32'h30; dma_wdata = 32'h55;
    for (int i = 0; i < 8; i++) begin
      dma_req = (i != 2);
      @(negedge clk);
      chk("t6_cpu_gnt", 0, cgnt[0], (i != 7));
      chk("t6_dma_gnt", 0, dgnt[0], (i == 7));
      chk("t6_stall", 0, stl[0], (i == 7));
      if (i == 7) begin
        chk("t6_mem_we", 0, mwe[0], 1);
        chk("t6_mem_addr", 0, maddr[0], 32'h30);
        chk("t6_mem_wdata", 0, mwd[0], 32'h55);
      end
      next();
    end
    idle(5);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
